// File: rtl/m_piled_undo_if.sv
// Handshake/data bundle between the game FSM and the piled-count undo stack.
interface m_piled_undo_if #(
    parameter int COL_COUNT = 7,
    parameter int COL_W     = 3,
    parameter int CNT_W     = 3,
    parameter int DEPTH_W   = 6
);
    logic                         i_clear;
    logic                         i_push;
    logic [COL_W-1:0]             i_push_col;
    logic                         i_undo_req;
    logic [COL_COUNT*CNT_W-1:0]   i_piled_count_array;
    logic                         o_undo_valid;
    logic [COL_W-1:0]             o_undo_col;
    logic [CNT_W-1:0]             o_undo_row;
    logic [COL_COUNT*CNT_W-1:0]   o_piled_count_array;
    logic                         o_undo_nack;
    logic                         o_busy;
    logic [DEPTH_W-1:0]           o_depth;
    logic                         o_empty;
    logic                         o_full;
    logic                         o_err;

    modport slave (
        input  i_clear, i_push, i_push_col, i_undo_req, i_piled_count_array,
        output o_undo_valid, o_undo_col, o_undo_row, o_piled_count_array,
        output o_undo_nack, o_busy, o_depth, o_empty, o_full, o_err
    );

    modport master (
        output i_clear, i_push, i_push_col, i_undo_req, i_piled_count_array,
        input  o_undo_valid, o_undo_col, o_undo_row, o_piled_count_array,
        input  o_undo_nack, o_busy, o_depth, o_empty, o_full, o_err
    );
endinterface

// File: rtl/m_piled_undo.sv
// Move-history LIFO for connect-four: pops the last dropped column and returns
// the piled-count array with that column's count decremented.
module m_piled_undo #(
    parameter int COL_COUNT = 7,
    parameter int ROW_COUNT = 6,
    parameter int COL_W     = 3,
    parameter int CNT_W     = 3,
    parameter int DEPTH     = COL_COUNT * ROW_COUNT,
    parameter int DEPTH_W   = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    m_piled_undo_if.slave   bus
);
    localparam int ARR_W = COL_COUNT * CNT_W;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, DEC} state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     mem [DEPTH];
    logic [COL_W-1:0]     rd_col;
    logic [DEPTH_W-1:0]   depth_q;
    logic [ARR_W-1:0]     cap_q, dec_arr;
    logic [CNT_W-1:0]     cap_cnt;
    logic                 empty, full, col_ok, push_ok, undo_go;
    logic                 valid_q, nack_q, err_q;
    logic [COL_W-1:0]     col_q;
    logic [CNT_W-1:0]     row_q;
    logic [ARR_W-1:0]     arr_q;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DEPTH_MAX);
    assign col_ok  = ({1'b0, bus.i_push_col} < (COL_W+1)'(COL_COUNT));
    assign push_ok = (state_q == IDLE) && bus.i_push && !full && col_ok;
    // A simultaneous push wins; the caller re-issues the undo.
    assign undo_go = (state_q == IDLE) && bus.i_undo_req && !bus.i_push && !empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)            state_q <= IDLE;
        else if (bus.i_clear) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (undo_go) state_d = RD;
            RD:      state_d = DEC;
            DEC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // History storage needs no reset; only entries below depth are ever read.
    always_ff @(posedge i_clk) begin
        if (push_ok && !bus.i_clear) mem[depth_q] <= bus.i_push_col;
        if (undo_go)                 rd_col <= mem[depth_q - 1'b1];
    end

    always_comb begin
        cap_cnt = '0;
        dec_arr = cap_q;
        for (int i = 0; i < COL_COUNT; i++) begin
            if (rd_col == COL_W'(i)) begin
                cap_cnt = cap_q[i*CNT_W +: CNT_W];
                dec_arr[i*CNT_W +: CNT_W] = cap_q[i*CNT_W +: CNT_W] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            depth_q <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            arr_q   <= '0;
        end else if (bus.i_clear) begin
            depth_q <= '0;
            valid_q <= 1'b0;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            arr_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            nack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_push) begin
                        if (push_ok) depth_q <= depth_q + 1'b1;
                        else         err_q   <= 1'b1;
                    end else if (bus.i_undo_req) begin
                        if (empty) nack_q <= 1'b1;
                        else       cap_q  <= bus.i_piled_count_array;
                    end
                end
                DEC: begin
                    if (bus.i_push) err_q <= 1'b1;
                    // A zero count means the board and history disagree.
                    if (cap_cnt == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        depth_q <= depth_q - 1'b1;
                        col_q   <= rd_col;
                        row_q   <= cap_cnt - 1'b1;
                        arr_q   <= dec_arr;
                        valid_q <= 1'b1;
                    end
                end
                default: if (bus.i_push) err_q <= 1'b1;
            endcase
        end
    end

    assign bus.o_undo_valid        = valid_q;
    assign bus.o_undo_nack         = nack_q;
    assign bus.o_undo_col          = col_q;
    assign bus.o_undo_row          = row_q;
    assign bus.o_piled_count_array = arr_q;
    assign bus.o_busy              = (state_q != IDLE);
    assign bus.o_depth             = depth_q;
    assign bus.o_empty             = empty;
    assign bus.o_full              = full;
    assign bus.o_err               = err_q;
endmodule
